jpeg_ycc_blockbuf: RTL and testbench
====================================

# jpeg_ycc_blockbuf

Parametrised colour-conversion and block-buffering front end for the JPEG pipeline. It accepts a raster RGB pixel stream under a valid/ready handshake and converts each pixel to signed YCbCr in fixed point. It assembles BLK_DIM×BLK_DIM blocks in a ping-pong buffer and streams each completed block to the DCT stage in row-major or column-major order. Input can fill one bank while the DCT drains the other.

## Interface
- PIX_W, 8, RGB component width (unsigned).
- BLK_DIM, 8, block edge; power of two, 4..16.
- OUT_W, 16, output sample width (signed, sign-extended).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle synchronous abort/clear: flushes both banks and all counters.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input can accept (combinational).
- R, G, B  in  PIX_W each  pixel components.
- col_major  in  1  read order for the next block drained (0 row-major, 1 column-major).
- out_valid  out  1  output sample valid.
- out_ready  in  1  DCT stage accepts sample.
- out_Y, out_Cb, out_Cr  out  OUT_W each  signed converted samples.
- out_last  out  1  high with the final sample of a block.
- blk_done  out  1  one-cycle pulse, registered, cycle after a block's last output transfer.

## Operation
- Conversion (combinational on accept, full-precision signed intermediates, arithmetic shift right = floor):
  - Y = ((77R + 150G + 29B) >> 8) − 128
  - Cb = (−43R − 85G + 128B) >> 8
  - Cr = (128R − 107G − 21B) >> 8
  - Ranges: Y −128..127; Cb and Cr −128..127. Coefficients are defined for PIX_W = 8. Other PIX_W values shift by 8 + (PIX_W − 8) and use −2^(PIX_W−1) as the Y offset.
- Storage: 2 banks × BLK_DIM² entries × 3 channels. State per bank: full flag. Pointers: wr_sel, rd_sel, write index wi, read index ri (each 2·log2(BLK_DIM) bits).
- Write side:
  - Accept when in_valid && in_ready. Store at bank[wr_sel][wi], then wi++.
  - On accepting wi = BLK_DIM²−1: set full[wr_sel], toggle wr_sel, wrap wi to 0.
  - in_ready = !rst && !start && !full[wr_sel].
- Read side:
  - out_valid = full[rd_sel].
  - Address: row-major = ri. Column-major = ri with its row and column fields swapped, i.e. output k maps to pixel (k mod BLK_DIM)·BLK_DIM + k/BLK_DIM.
  - col_major is latched into rd_mode on every edge where ri = 0 and no transfer occurs. rd_mode is held for the whole block.
  - On out_valid && out_ready: ri++.
  - At ri = BLK_DIM²−1 (out_last = 1): clear full[rd_sel], toggle rd_sel, wrap ri to 0, and pulse blk_done next cycle.
- Concurrency:
  - Write and read always target different banks: the writer needs an empty bank, the reader a full one.
  - Completing a write bank and draining a read bank on the same edge are independent and must both take effect.
- start: same effect as rst on all state. It takes priority over a simultaneous handshake, so the pixel presented in the start cycle is not accepted.

## Timing
- Reset values:
  - in_ready 0 while rst = 1, 1 the first cycle after.
  - out_valid 0, out_last 0, blk_done 0.
  - out_Y/Cb/Cr: don't-care while out_valid = 0. Model holds 0.
  - wr_sel = rd_sel = 0, wi = ri = 0, both full flags clear, rd_mode 0.
- Throughput: one pixel in and one sample out per cycle, sustained.
- Latency: out_valid rises the cycle after the edge accepting a block's last pixel. With out_ready held high, first-in to first-out is BLK_DIM² cycles.
- Both banks full: in_ready = 0 until the edge completing the current read bank. in_ready rises the following cycle.
- Output data is a combinational read of the buffer. It is stable while out_valid && !out_ready.

## Configuration
- Macro JPEG_LEVEL_SHIFT_EN:
  - Defined: Y is level-shifted as above (signed −128..127).
  - Undefined: no −128 offset. Y = (77R+150G+29B)>>8 is zero-extended to OUT_W (0..255). Cb and Cr are unchanged.

## Test plan
- Reset and colour points, level shift on, out_ready = 1. Each pixel is checked at the sample it lands on in a fully drained block.
  - (255,255,255) → Y 127, Cb 0, Cr 0.
  - (255,0,0) → Y −52, Cb −43, Cr 127.
  - (0,0,0) → Y −128, Cb 0, Cr 0.
- Same points with JPEG_LEVEL_SHIFT_EN undefined: (0,0,0) → Y 0; (255,0,0) → Y 76.
- Ramp R=i, G=i+1, B=i+2, i = 0..63, BLK_DIM = 8.
  - col_major = 0: output k equals the conversion of pixel k.
  - col_major = 1: output 1 equals pixel 8 and output 63 equals pixel 63.
  - out_last and blk_done fire exactly once per block, with blk_done one cycle after out_last.
- Backpressure: out_ready = 0, feed 129 pixels.
  - in_ready drops after the 128th acceptance.
  - Raise out_ready: 64 transfers, then in_ready rises and the 129th pixel is accepted. No data loss or reordering across 3 blocks.
- Random in_valid/out_ready (50%) over 20 blocks: scoreboard exact match, including a bank finishing on both sides in the same edge.
- start pulsed mid-block (wi = 30, ri = 10): next cycle out_valid = 0, the in-flight pixel is dropped, and the next 64 pixels form a fresh block starting at bank 0.

Source files
------------

// File: rtl/jpeg_ycc_blockbuf.sv
// jpeg_ycc_blockbuf
//   RGB -> signed YCbCr colour conversion feeding a ping-pong block buffer.
//   Pixels arrive in raster order; each BLK_DIM x BLK_DIM block is stored in
//   one bank and streamed to the DCT stage row- or column-major while the
//   other bank fills.
//
// Optional feature macro: JPEG_LEVEL_SHIFT_EN
//   defined   : Y is level-shifted by -2^(PIX_W-1) (signed range)
//   undefined : Y is left unsigned (0 .. 2^PIX_W-1), zero-extended
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle clear of both banks and all pointers
//   in_valid/in_ready  input pixel handshake (in_ready combinational)
//   R, G, B            unsigned pixel components
//   col_major          read order for the next block drained
//   out_valid/out_ready output sample handshake
//   out_Y/Cb/Cr        signed converted samples
//   out_last           final sample of a block
//   blk_done           registered pulse the cycle after a block's last transfer
`timescale 1ns/1ps

module jpeg_ycc_blockbuf #(
    parameter int PIX_W   = 8,
    parameter int BLK_DIM = 8,
    parameter int OUT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIX_W-1:0]        R,
    input  logic [PIX_W-1:0]        G,
    input  logic [PIX_W-1:0]        B,
    input  logic                    col_major,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_Y,
    output logic signed [OUT_W-1:0] out_Cb,
    output logic signed [OUT_W-1:0] out_Cr,
    output logic                    out_last,
    output logic                    blk_done
);

    localparam int LOG  = $clog2(BLK_DIM);
    localparam int IW   = 2 * LOG;
    localparam int NPIX = BLK_DIM * BLK_DIM;
    // Products are at most 256 * (2^PIX_W - 1); a few guard bits plus sign.
    localparam int CW   = PIX_W + 11;

    localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

    localparam logic signed [CW-1:0] K21  = CW'(21);
    localparam logic signed [CW-1:0] K29  = CW'(29);
    localparam logic signed [CW-1:0] K43  = CW'(43);
    localparam logic signed [CW-1:0] K77  = CW'(77);
    localparam logic signed [CW-1:0] K85  = CW'(85);
    localparam logic signed [CW-1:0] K107 = CW'(107);
    localparam logic signed [CW-1:0] K128 = CW'(128);
    localparam logic signed [CW-1:0] K150 = CW'(150);
`ifdef JPEG_LEVEL_SHIFT_EN
    localparam logic signed [CW-1:0] Y_OFF = CW'(1) << (PIX_W - 1);
`endif

    // ------------------------------------------------------------------
    // Colour conversion (combinational, on the accepted pixel)
    // ------------------------------------------------------------------
    logic signed [CW-1:0] r_s, g_s, b_s;
    logic signed [CW-1:0] y_acc, cb_acc, cr_acc;
    logic signed [CW-1:0] y_sh, cb_sh, cr_sh;
    logic signed [OUT_W-1:0] y_cv, cb_cv, cr_cv;

    assign r_s = $signed({{(CW-PIX_W){1'b0}}, R});
    assign g_s = $signed({{(CW-PIX_W){1'b0}}, G});
    assign b_s = $signed({{(CW-PIX_W){1'b0}}, B});

    assign y_acc  = K77 * r_s + K150 * g_s + K29 * b_s;
    assign cb_acc = K128 * b_s - K43 * r_s - K85 * g_s;
    assign cr_acc = K128 * r_s - K107 * g_s - K21 * b_s;

    // Arithmetic shift gives floor division for the negative chroma terms.
`ifdef JPEG_LEVEL_SHIFT_EN
    assign y_sh  = (y_acc >>> PIX_W) - Y_OFF;
`else
    assign y_sh  = y_acc >>> PIX_W;
`endif
    assign cb_sh = cb_acc >>> PIX_W;
    assign cr_sh = cr_acc >>> PIX_W;

    assign y_cv  = OUT_W'(y_sh);
    assign cb_cv = OUT_W'(cb_sh);
    assign cr_cv = OUT_W'(cr_sh);

    // ------------------------------------------------------------------
    // Ping-pong storage, addressed {bank, index}
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0] mem_y  [0:2*NPIX-1];
    logic signed [OUT_W-1:0] mem_cb [0:2*NPIX-1];
    logic signed [OUT_W-1:0] mem_cr [0:2*NPIX-1];

    logic [1:0]    full;
    logic          wr_sel, rd_sel, rd_mode;
    logic [IW-1:0] wi, ri, rd_addr;
    logic          wr_acc, rd_xfer;

    assign in_ready  = !rst && !start && !full[wr_sel];
    assign wr_acc    = in_valid && in_ready;
    assign out_valid = full[rd_sel];
    assign rd_xfer   = out_valid && out_ready;
    assign out_last  = out_valid && (ri == LAST_IDX);

    // Column-major swaps the row/column fields of the read index.
    assign rd_addr = rd_mode ? {ri[LOG-1:0], ri[IW-1:LOG]} : ri;

    assign out_Y  = out_valid ? mem_y [{rd_sel, rd_addr}] : '0;
    assign out_Cb = out_valid ? mem_cb[{rd_sel, rd_addr}] : '0;
    assign out_Cr = out_valid ? mem_cr[{rd_sel, rd_addr}] : '0;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_y [{wr_sel, wi}] <= y_cv;
            mem_cb[{wr_sel, wi}] <= cb_cv;
            mem_cr[{wr_sel, wi}] <= cr_cv;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and bank flags. Writer and reader always own different
    // banks, so a write completion and a read completion on the same edge
    // touch different full[] bits and both take effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || start) begin
            full     <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            wi       <= '0;
            ri       <= '0;
            rd_mode  <= 1'b0;
            blk_done <= 1'b0;
        end else begin
            if (wr_acc) begin
                wi <= wi + 1'b1;
                if (wi == LAST_IDX) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                end
            end
            if (rd_xfer) begin
                ri <= ri + 1'b1;
                if (ri == LAST_IDX) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end
            end else if (ri == '0) begin
                // Order is only sampled between blocks, held for the block.
                rd_mode <= col_major;
            end
            blk_done <= rd_xfer && (ri == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_jpeg_ycc_blockbuf.sv
`timescale 1ns/1ps

module tb_jpeg_ycc_blockbuf;

    localparam int PW = 8;
    localparam int BD = 8;
    localparam int OW = 16;
    localparam int NP = BD * BD;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, col_major;
    logic out_valid, out_ready, out_last, blk_done;
    logic [PW-1:0] R, G, B;
    logic signed [OW-1:0] out_Y, out_Cb, out_Cr;

    always #5 clk = ~clk;

    jpeg_ycc_blockbuf #(.PIX_W(PW), .BLK_DIM(BD), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .R(R), .G(G), .B(B), .col_major(col_major),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_Y(out_Y), .out_Cb(out_Cb), .out_Cr(out_Cr),
        .out_last(out_last), .blk_done(blk_done)
    );

    typedef struct {
        int y;
        int cb;
        int cr;
        bit last;
    } smp_t;

    smp_t exp_q[$];
    smp_t blk_buf[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, last_cnt = 0, done_cnt = 0;
    int   first_in = -1, first_out = -1;
    int   rdy_mode = 0;      // 0 low, 1 high, 2 random
    bit   done_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic smp_t conv(input int r, input int g, input int b);
        smp_t s;
        s.y  = (77 * r + 150 * g + 29 * b) >>> 8;
`ifdef JPEG_LEVEL_SHIFT_EN
        s.y  = s.y - 128;
`endif
        s.cb = (128 * b - 43 * r - 85 * g) >>> 8;
        s.cr = (128 * r - 107 * g - 21 * b) >>> 8;
        s.last = 1'b0;
        return s;
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(1) == 1);
        end
    end

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rst) begin
            done_exp = 1'b0;
        end else begin
            chk("blk_done", int'(blk_done), int'(done_exp));
            if (blk_done) done_cnt++;
            done_exp = out_valid && out_ready && out_last;
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = cyc;
                if (out_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got Y=%0d with empty scoreboard", out_Y);
                end else begin
                    smp_t e;
                    e = exp_q.pop_front();
                    chk("out_Y",    int'(out_Y),    e.y);
                    chk("out_Cb",   int'(out_Cb),   e.cb);
                    chk("out_Cr",   int'(out_Cr),   e.cr);
                    chk("out_last", int'(out_last), int'(e.last));
                end
            end
        end
    end

    // Present one pixel until accepted; gap is the percent chance of
    // idling in_valid each cycle. xf counts output transfers seen before
    // the accepting cycle.
    task automatic send_px(input int r, input int g, input int b, input smp_t e,
                           input int gap, output int xf);
        bit ok;
        ok = 1'b0;
        xf = 0;
        for (int n = 0; n < 4000 && !ok; n++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(99) >= gap);
            R = PW'(r);
            G = PW'(g);
            B = PW'(b);
            @(negedge clk);
            if (in_valid && in_ready) ok = 1'b1;
            else if (out_valid && out_ready) xf++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: pixel (%0d,%0d,%0d) not accepted", r, g, b);
            return;
        end
        if (first_in < 0) first_in = cyc;
        blk_buf.push_back(e);
        if (blk_buf.size() == NP) begin
            for (int k = 0; k < NP; k++) begin
                smp_t s;
                int idx;
                idx = col_major ? (k % BD) * BD + k / BD : k;
                s = blk_buf[idx];
                s.last = (k == NP - 1);
                exp_q.push_back(s);
            end
            blk_buf.delete();
        end
    endtask

    task automatic sp(input int r, input int g, input int b, input int gap);
        int xf;
        send_px(r, g, b, conv(r, g, b), gap, xf);
    endtask

    task automatic sp_h(input int r, input int g, input int b,
                        input int y, input int cb, input int cr);
        smp_t e;
        int xf;
        e.y = y; e.cb = cb; e.cr = cr; e.last = 1'b0;
        send_px(r, g, b, e, 0, xf);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        rdy_mode = 1;
        for (int n = 0; n < 5000 && !ok; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d samples still expected", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int yw, yr, yk, xf, cnt;
`ifdef JPEG_LEVEL_SHIFT_EN
        yw = 127; yr = -52; yk = -128;
`else
        yw = 255; yr = 76;  yk = 0;
`endif
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; col_major = 1'b0;
        R = '0; G = '0; B = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last",  int'(out_last),  0);
        chk("rst_blk_done",  int'(blk_done),  0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready",  int'(in_ready),  1);
        chk("post_rst_out_valid", int'(out_valid), 0);

        // Colour points (hand values), plus first-in to first-out latency
        rdy_mode = 1;
        first_in = -1;
        first_out = -1;
        sp_h(255, 255, 255, yw, 0, 0);
        sp_h(255, 0, 0, yr, -43, 127);
        sp_h(0, 0, 0, yk, 0, 0);
        for (int i = 3; i < NP; i++) sp_h(0, 0, 0, yk, 0, 0);
        idle();
        wait_drain();
        chk("latency", first_out - first_in, NP);

        // Ramp, row-major, three blocks streamed back to back
        col_major = 1'b0;
        for (int blk = 0; blk < 3; blk++)
            for (int i = 0; i < NP; i++) sp(i + blk * 20, i + blk * 20 + 1, i + blk * 20 + 2, 0);
        idle();
        wait_drain();

        // Ramp, column-major
        col_major = 1'b1;
        for (int i = 0; i < NP; i++) sp(i, i + 1, i + 2, 0);
        idle();
        wait_drain();
        col_major = 1'b0;
        @(negedge clk);

        // Backpressure: fill both banks, then release
        rdy_mode = 0;
        for (int i = 0; i < 2 * NP; i++) sp((i * 3) & 255, 255 - i, (i * 7) & 255, 0);
        idle();
        @(negedge clk);
        chk("bp_in_ready_low", int'(in_ready), 0);
        chk("bp_out_valid",    int'(out_valid), 1);
        rdy_mode = 1;
        send_px(11, 22, 33, conv(11, 22, 33), 0, xf);
        chk("bp_xfers_before_accept", xf, NP);
        for (int i = 1; i < NP; i++) sp(i * 2, 200 - i, i, 0);
        idle();
        wait_drain();

        // Random handshakes, column-major, 20 blocks
        col_major = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 20 * NP; i++)
            sp($urandom_range(255), $urandom_range(255), $urandom_range(255), 50);
        idle();
        wait_drain();
        col_major = 1'b0;
        @(negedge clk);

        // start mid-block: bank 0 read to ri=10, bank 1 written to wi=30
        rdy_mode = 0;
        for (int i = 0; i < NP; i++) sp(i, 2 * i, 3 * i, 0);
        idle();
        rdy_mode = 1;
        cnt = 0;
        for (int n = 0; n < 100 && cnt < 10; n++) begin
            @(negedge clk);
            if (out_valid && out_ready) cnt++;
        end
        rdy_mode = 0;
        chk("pre_start_xfers", cnt, 10);
        for (int i = 0; i < 30; i++) sp(100 + i, 50, 25, 0);
        @(posedge clk);
        #1;
        start = 1'b1;
        in_valid = 1'b1;
        R = 8'd200; G = 8'd200; B = 8'd200;
        @(negedge clk);
        chk("start_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        blk_buf.delete();
        @(negedge clk);
        chk("start_out_valid", int'(out_valid), 0);
        chk("start_in_ready_back", int'(in_ready), 1);
        rdy_mode = 1;
        for (int i = 0; i < NP; i++) sp(255 - i, i, 128, 0);
        idle();
        wait_drain();

        chk("out_last_count", last_cnt, 29);
        chk("blk_done_count", done_cnt, 29);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
